fetch_stage: RTL and testbench

Parametrised successor to the single-cycle instruction fetch block. It owns the program counter and issues sequential word fetches into the existing `memory` instance (read-only). Returned instructions go into a small prefetch FIFO and are presented downstream with a valid/ready handshake. Branch/jump redirects from execute flush all fetched-but-unconsumed work and restart fetch at the target.

---
 rtl/mips_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/memory.sv | 24 ++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch path.
package mips_pkg;

    localparam int INSTR_WIDTH    = 32;
    localparam int PC_STEP        = 4;
    // Widest PC a fetch entry can carry; narrower PCs are zero-extended.
    localparam int ENTRY_PC_WIDTH = 32;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [ENTRY_PC_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO. The pointers wrap at DEPTH, so DEPTH does not need to
// be a power of two. The count tracks occupancy. Flush takes priority over
// push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entry storage: write the tail slot on a push that is not being flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
        end else if (push && !flush) begin
            store_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy update. Push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = store_q[rd_ptr_q];
    assign count = count_q;

    // The upstream credit scheme must never push into a full FIFO.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/memory.sv
// Word-addressed instruction memory with a synchronous read. Read data
// appears the cycle after the address is presented.
module memory #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 18
) (
    input  logic                 clk,
    input  logic                 write,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [DATAWIDTH-1:0] in,
    output logic [DATAWIDTH-1:0] out
);

    logic [DATAWIDTH-1:0] mem [0:(1<<ADDRWIDTH)-1];

    // Optional write, then a registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[addr] <= in;
        end
        out <= mem[addr];
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. It owns the PC and issues one sequential word
// fetch per cycle while there is credit. Returned words are buffered in a
// prefetch FIFO. Redirects flush all fetched but unconsumed work.
//
// Output handshake: the consumer takes the head entry in a cycle where both
// out_valid and out_ready are high. While out_valid is high and out_ready is
// low, out_pc and out_instr hold steady. out_valid never depends on out_ready.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    MEM_ADDR_WIDTH = 18,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int                    FIFO_DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  inflight_pc_q;
    logic                   inflight_q;
    logic [CNT_W-1:0]       count;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic [SUM_W-1:0]       credit_used;
    logic                   pop;
    logic                   push;
    logic                   issue;
    fetch_entry_t           push_entry;
    fetch_entry_t           head_entry;
    logic                   unused_bits;

    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q && !redirect_valid;

    // Buffered entries plus the outstanding fetch, minus what leaves this
    // cycle, must stay below the depth so every returning word has a slot.
    assign credit_used = SUM_W'(count) + SUM_W'(inflight_q) - SUM_W'(pop);
    assign issue       = !redirect_valid && (credit_used < SUM_W'(FIFO_DEPTH));

    // Pair the returning memory word with the PC it was fetched from.
    always_comb begin
        push_entry       = '0;
        push_entry.pc    = ENTRY_PC_WIDTH'(inflight_pc_q);
        push_entry.instr = mem_rdata;
    end

    // PC, in-flight flag and in-flight PC. A redirect reloads the PC and drops the outstanding fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q       <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + ADDR_WIDTH'(PC_STEP);
            end
        end
    end

    memory #(
        .DATAWIDTH (INSTR_WIDTH),
        .ADDRWIDTH (MEM_ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .write (1'b0),
        .addr  (pc_q[MEM_ADDR_WIDTH+1:2]),
        .in    ({INSTR_WIDTH{1'b0}}),
        .out   (mem_rdata)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .head  (head_entry),
        .count (count)
    );

    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc[ADDR_WIDTH-1:0];

    // Redirect target low bits are ignored. Padding above ADDR_WIDTH is always zero.
    assign unused_bits = ^{head_entry.pc, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam int         PRELOAD    = 4096;
    localparam logic [7:0] W_RESET_PC = 8'hF8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic        w_valid;
    logic [31:0] w_instr;
    logic [7:0]  w_pc;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    // Narrow-PC instance used to observe wrap-around of the PC.
    fetch_stage #(
        .ADDR_WIDTH     (8),
        .MEM_ADDR_WIDTH (6),
        .RESET_PC       (W_RESET_PC),
        .FIFO_DEPTH     (2)
    ) dut_w (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (1'b0),
        .redirect_pc    (8'h00),
        .out_valid      (w_valid),
        .out_ready      (1'b1),
        .out_instr      (w_instr),
        .out_pc         (w_pc)
    );

    // ---------------- scoreboard ----------------
    int n_compared = 0;
    int n_mismatched = 0;

    logic [63:0] exp_q[$];
    logic [39:0] wrap_q[$];
    logic [31:0] model_pc = '0;
    logic [31:0] first_pc = '0;
    int unsigned exp_first_cyc = 0;
    bit          wait_first = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Memory image: word i holds 0x100 + i.
    function automatic logic [31:0] model_word(input logic [31:0] pc);
        return 32'h100 + (pc >> 2);
    endfunction

    task automatic model_refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back({model_pc, model_word(model_pc)});
            model_pc = model_pc + 32'd4;
        end
    endtask

    // After a restart the stream is target, target+4, ... and first appears after 'latency' cycles.
    task automatic model_restart(input logic [31:0] start_pc, input int unsigned latency);
        exp_q.delete();
        model_pc      = {start_pc[31:2], 2'b00};
        first_pc      = model_pc;
        exp_first_cyc = cyc + latency;
        wait_first    = 1'b1;
        model_refill();
    endtask

    // Narrow instance: 8-bit PC wraps; its memory word i holds 0x200 + i.
    task automatic wrap_restart();
        logic [7:0] p;
        p = W_RESET_PC;
        wrap_q.delete();
        for (int k = 0; k < 4; k++) begin
            wrap_q.push_back({p, 32'h200 + 32'(p / 8'd4)});
            p = p + 8'd4;
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        logic [63:0] e;
        logic [39:0] we;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (redirect_valid) begin
                check("valid_during_redirect", 64'(out_valid), 64'd0);
            end
            if (prev_valid && !redirect_valid) begin
                check("no_bubble", 64'(out_valid), 64'd1);
                if (!prev_ready) begin
                    check("hold_stable", {out_pc, out_instr}, prev_data);
                end
            end
            if (wait_first && (out_valid || cyc >= exp_first_cyc)) begin
                check("first_valid_cycle", 64'(cyc), 64'(exp_first_cyc));
                check("first_valid", 64'(out_valid), 64'd1);
                check("first_pc", 64'(out_pc), 64'(first_pc));
                wait_first = 1'b0;
            end
            if (out_valid && out_ready) begin
                check("exp_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_pc", 64'(out_pc), 64'(e[63:32]));
                    check("out_instr", 64'(out_instr), 64'(e[31:0]));
                end
            end
            if (w_valid && wrap_q.size() != 0) begin
                we = wrap_q.pop_front();
                check("wrap_pc", 64'(w_pc), 64'(we[39:32]));
                check("wrap_instr", 64'(w_instr), 64'(we[31:0]));
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = {out_pc, out_instr};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        model_refill();
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_w_valid", 64'(w_valid), 64'd0);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        model_restart(32'h0, 2);
        wrap_restart();
    endtask

    // Assert reset between clock edges and check outputs clear with no clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        wrap_q.delete();
        wait_first = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        tick();
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        model_restart(target, 3);
        tick();
        redirect_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < PRELOAD; i++) begin
            dut.u_mem.mem[i] = 32'h100 + 32'(i);
        end
        for (int i = 0; i < 64; i++) begin
            dut_w.u_mem.mem[i] = 32'h200 + 32'(i);
        end

        // Power-on reset, then stream with ready held high.
        out_ready = 1'b1;
        tick();
        check_reset_outputs();
        tick();
        release_reset();
        repeat (25) tick();

        // Stall from the first valid for 12 cycles, then release.
        async_reset();
        out_ready = 1'b0;
        release_reset();
        repeat (12) tick();
        out_ready = 1'b1;
        repeat (10) tick();

        // Redirect while the FIFO is full.
        out_ready = 1'b0;
        repeat (4) tick();
        redirect(32'h40);
        out_ready = 1'b1;
        repeat (10) tick();

        // Redirect while streaming with a fetch in flight.
        redirect(32'h100);
        repeat (6) tick();

        // Back-to-back redirects: the last one wins.
        redirect(32'h43);
        redirect(32'h80);
        repeat (10) tick();

        // Randomized ready and redirects, with one asynchronous reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (n == 700) begin
                async_reset();
                release_reset();
            end else if ($urandom_range(0, 19) == 0) begin
                redirect(32'($urandom_range(0, 32'h1FFF)));
            end else begin
                tick();
            end
        end

        out_ready = 1'b1;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
